// File: rtl/seg_pkg.sv
// seg_pkg: shared active-low 7-segment codes and the hex-to-segment decoder
package seg_pkg;
    localparam logic [7:0] SEG_0 = 8'hC0, SEG_1 = 8'hF9, SEG_2 = 8'hA4, SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99, SEG_5 = 8'h92, SEG_6 = 8'h82, SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80, SEG_9 = 8'h90, SEG_A = 8'h88, SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6, SEG_D = 8'hA1, SEG_E = 8'h86, SEG_F = 8'h8E;
    localparam logic [7:0] SEG_IDLE = 8'hFF;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        case (hex)
            4'h0: return SEG_0[6:0];
            4'h1: return SEG_1[6:0];
            4'h2: return SEG_2[6:0];
            4'h3: return SEG_3[6:0];
            4'h4: return SEG_4[6:0];
            4'h5: return SEG_5[6:0];
            4'h6: return SEG_6[6:0];
            4'h7: return SEG_7[6:0];
            4'h8: return SEG_8[6:0];
            4'h9: return SEG_9[6:0];
            4'hA: return SEG_A[6:0];
            4'hB: return SEG_B[6:0];
            4'hC: return SEG_C[6:0];
            4'hD: return SEG_D[6:0];
            4'hE: return SEG_E[6:0];
            default: return SEG_F[6:0];
        endcase
    endfunction
endpackage

// File: rtl/seg_dynamic_if.sv
// seg_dynamic_if: host data strobe plus display pin bundle for seg_dynamic
interface seg_dynamic_if #(parameter int DIGITS = 6);
    logic                  load;
    logic [4*DIGITS-1:0]   data_in;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     blank_in;
    logic                  lz_en;
    logic [DIGITS-1:0]     sel;
    logic [7:0]            seg;
    logic                  load_pend;
    logic                  frame_done;

    modport master (output load, data_in, dp_in, blank_in, lz_en,
                    input sel, seg, load_pend, frame_done);
    modport slave  (input load, data_in, dp_in, blank_in, lz_en,
                    output sel, seg, load_pend, frame_done);
endinterface

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: slot counter and digit index; commit marks the last cycle of a frame
module seg_scan_timer #(
    parameter int DIGITS       = 6,
    parameter int SCAN_CNT_MAX = 49_999,
    parameter int CNT_W        = 16
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    output logic [CNT_W-1:0]          cnt_scan,
    output logic [$clog2(DIGITS)-1:0] digit_idx,
    output logic                      commit
);
    localparam int IDX_W = $clog2(DIGITS);
    logic slot_wrap;

    assign slot_wrap = cnt_scan == CNT_W'(SCAN_CNT_MAX);
    assign commit    = slot_wrap && digit_idx == IDX_W'(DIGITS - 1);

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            cnt_scan  <= '0;
            digit_idx <= '0;
        end else begin
            cnt_scan <= slot_wrap ? '0 : cnt_scan + 1'b1;
            if (slot_wrap) digit_idx <= commit ? '0 : digit_idx + 1'b1;
        end
endmodule

// File: rtl/seg_dynamic.sv
// seg_dynamic: multiplexed 7-segment driver with per-digit hex/dp, leading-zero
// suppression, slot blanking and a shadow buffer committed only at frame end
module seg_dynamic
    import seg_pkg::*;
#(
    parameter int DIGITS       = 6,
    parameter int SCAN_CNT_MAX = 49_999,
    parameter int BLANK_CYC    = 500,
    parameter int CNT_W        = 16
) (
    input logic          sys_clk,
    input logic          sys_rst_n,
    seg_dynamic_if.slave bus
);
    localparam int IDX_W = $clog2(DIGITS);

    logic [CNT_W-1:0]    cnt_scan;
    logic [IDX_W-1:0]    digit_idx;
    logic                commit;
    logic [4*DIGITS-1:0] shadow_data, active_data;
    logic [DIGITS-1:0]   shadow_dp, active_dp, shadow_blank, active_blank;
    logic [DIGITS-1:0]   dark;
    logic                zero_run;
    logic [3:0]          nib;

    seg_scan_timer #(
        .DIGITS(DIGITS), .SCAN_CNT_MAX(SCAN_CNT_MAX), .CNT_W(CNT_W)
    ) u_timer (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cnt_scan(cnt_scan), .digit_idx(digit_idx), .commit(commit)
    );

    // walk down from the most significant digit while every digit so far is an undotted zero
    always_comb begin
        dark     = active_blank;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run & (active_data[4*k +: 4] == 4'd0) & ~active_dp[k];
            dark[k]  = dark[k] | (bus.lz_en & zero_run);
        end
    end

    assign nib = active_data[{digit_idx, 2'b00} +: 4];

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            shadow_data    <= '0;
            shadow_dp      <= '0;
            shadow_blank   <= '0;
            active_data    <= '0;
            active_dp      <= '0;
            active_blank   <= '0;
            bus.load_pend  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.sel        <= '0;
            bus.seg        <= SEG_IDLE;
        end else begin
            if (bus.load) begin
                shadow_data  <= bus.data_in;
                shadow_dp    <= bus.dp_in;
                shadow_blank <= bus.blank_in;
            end
            if (commit && bus.load_pend) begin
                active_data  <= shadow_data;
                active_dp    <= shadow_dp;
                active_blank <= shadow_blank;
            end
            bus.load_pend  <= bus.load | (bus.load_pend & ~commit);
            bus.frame_done <= commit;
            bus.sel        <= DIGITS'(1) << digit_idx;
            bus.seg        <= (cnt_scan < CNT_W'(BLANK_CYC) || dark[digit_idx]) ? SEG_IDLE
                                : {~active_dp[digit_idx], hex_to_seg(nib)};
        end
endmodule

// File: tb/tb_seg_dynamic.sv
// tb_seg_dynamic: directed and randomized checks of seg_dynamic against a frame-level model
module tb_seg_dynamic;
    localparam int DIGITS = 6, SCAN = 9, BLANK = 2, SLOT = SCAN + 1, FRAME = DIGITS * SLOT;
    localparam logic [7:0] HEX_TAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic sys_clk = 1'b0, sys_rst_n = 1'b0;
    seg_dynamic_if #(.DIGITS(DIGITS)) bus ();

    seg_dynamic #(.DIGITS(DIGITS), .SCAN_CNT_MAX(SCAN), .BLANK_CYC(BLANK), .CNT_W(16)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0, n_bad = 0;
    int mc;
    logic [23:0] sh_d, ac_d;
    logic [5:0]  sh_dp, ac_dp, sh_bl, ac_bl;
    bit          m_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, mc, got, exp);
        end
    endtask

    // digit k is dark under lz_en when it sits above the highest digit carrying a value or a dp
    function automatic logic [7:0] ref_seg(int k, int cnt, logic [23:0] d, logic [5:0] dp,
                                           logic [5:0] bl, logic lz);
        int msd = 0;
        for (int j = 1; j < DIGITS; j++) if (d[4*j +: 4] != 0 || dp[j]) msd = j;
        if (cnt < BLANK || bl[k] || (lz && k > msd)) return 8'hFF;
        return HEX_TAB[d[4*k +: 4]] & (dp[k] ? 8'h7F : 8'hFF);
    endfunction

    task automatic model_reset();
        mc = 0; sh_d = 0; ac_d = 0; sh_dp = 0; ac_dp = 0; sh_bl = 0; ac_bl = 0; m_pend = 0;
    endtask

    task automatic load_vals(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl);
        bus.load = 1'b1; bus.data_in = d; bus.dp_in = dp; bus.blank_in = bl;
    endtask

    task automatic step();
        int  cnt = mc % SLOT, idx = (mc / SLOT) % DIGITS;
        bit  commit = (mc % FRAME) == FRAME - 1;
        logic [5:0] e_sel = 6'b1 << idx;
        logic [7:0] e_seg = ref_seg(idx, cnt, ac_d, ac_dp, ac_bl, bus.lz_en);
        if (commit && m_pend) begin ac_d = sh_d; ac_dp = sh_dp; ac_bl = sh_bl; end
        if (bus.load) begin sh_d = bus.data_in; sh_dp = bus.dp_in; sh_bl = bus.blank_in; m_pend = 1; end
        else if (commit) m_pend = 0;
        mc++;
        @(posedge sys_clk);
        @(negedge sys_clk);
        bus.load = 1'b0;
        check("sel", bus.sel, e_sel);
        check("seg", bus.seg, e_seg);
        check("load_pend", bus.load_pend, m_pend);
        check("frame_done", bus.frame_done, commit);
    endtask

    initial begin
        bus.load = 0; bus.data_in = 0; bus.dp_in = 0; bus.blank_in = 0; bus.lz_en = 0;
        model_reset();
        repeat (2) @(negedge sys_clk);
        check("rst_sel", bus.sel, 0);
        check("rst_seg", bus.seg, 8'hFF);
        check("rst_pend", bus.load_pend, 0);
        check("rst_fd", bus.frame_done, 0);
        sys_rst_n = 1'b1;
        repeat (FRAME + 5) step();
        load_vals(24'h123456, 6'b000100, 6'b0);
        repeat (2 * FRAME) step();
        bus.lz_en = 1;
        load_vals(24'h000070, 6'b0, 6'b0);
        repeat (2 * FRAME) step();
        load_vals(24'h000070, 6'b001000, 6'b0);
        repeat (2 * FRAME) step();
        bus.lz_en = 0;
        load_vals(24'h111111, 6'b0, 6'b0);
        repeat (7) step();
        load_vals(24'h222222, 6'b0, 6'b0);
        repeat (2 * FRAME) step();
        for (int i = 0; i < FRAME && mc % FRAME != FRAME - 1; i++) step();
        load_vals(24'h333333, 6'b0, 6'b0);
        repeat (2 * FRAME + 3) step();
        load_vals(24'hFFFFFF, 6'b0, 6'b100001);
        repeat (2 * FRAME) step();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) == 0) bus.lz_en = ~bus.lz_en;
            if ($urandom_range(19) == 0) begin
                case ($urandom_range(2))
                    0: load_vals(24'($urandom), 6'($urandom), 6'($urandom));
                    1: load_vals(24'($urandom) & 24'h000FFF, 6'b0, 6'b0);
                    default: load_vals(24'($urandom_range(15)) << (4 * $urandom_range(5)),
                                       6'($urandom) & 6'b000011, 6'b0);
                endcase
            end
            step();
        end
        for (int i = 0; i < FRAME && (mc / SLOT) % DIGITS != 3; i++) step();
        load_vals(24'h987654, 6'b111111, 6'b0);
        repeat (2) step();
        check("pend_before_rst", bus.load_pend, 1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_sel", bus.sel, 0);
        check("async_seg", bus.seg, 8'hFF);
        check("async_pend", bus.load_pend, 0);
        check("async_fd", bus.frame_done, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
        repeat (3 * FRAME) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
